// File: rtl/argmin_pkg.sv
// argmin_pkg: definitions shared by the argmin reduction tree and the
// multi-channel source blocks that feed it.
//   ARGMIN_N / ARGMIN_WIDTH : default channel count and channel width
//   LT_W                    : width of the common compare datapath
//   argmin_levels(n)        : number of compare levels for n channels
//   lt(a, b, signed_mode)   : strict a < b, two's-complement or unsigned
package argmin_pkg;

  localparam int ARGMIN_N     = 4;
  localparam int ARGMIN_WIDTH = 32;

  // Every node compares in this common width. Callers sign- or zero-extend
  // their operands according to the compare mode, so channel widths up to
  // LT_W bits are supported.
  localparam int LT_W = 64;

  function automatic int argmin_levels(input int n);
    int l;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << l) < n) l++;
    end
    return l;
  endfunction

  function automatic logic lt(input logic [LT_W-1:0] a,
                              input logic [LT_W-1:0] b,
                              input logic            signed_mode);
    logic signed [LT_W-1:0] sa;
    logic signed [LT_W-1:0] sb;
    sa = a;
    sb = b;
    if (signed_mode) return sa < sb;
    else             return a < b;
  endfunction

endpackage

// File: rtl/argmin_cmp2.sv
// argmin_cmp2: combinational two-operand node of the argmin tree.
// Picks the right operand only when it is strictly smaller than the left,
// so ties resolve to the left (lower-index) operand.
// Optional feature macro: ARGMIN_TREE_MASK_EN adds a "present" bit per
// operand; an absent operand never wins against a present one, and when
// both are absent the winner is forced to value 0, index 0, absent.
// Ports:
//   l_val/l_idx[/l_pres] : left operand
//   r_val/r_idx[/r_pres] : right operand
//   w_val/w_idx[/w_pres] : winner
module argmin_cmp2
  import argmin_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IDXW   = 2,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] l_val,
  input  logic [IDXW-1:0]  l_idx,
  input  logic [WIDTH-1:0] r_val,
  input  logic [IDXW-1:0]  r_idx,
`ifdef ARGMIN_TREE_MASK_EN
  input  logic             l_pres,
  input  logic             r_pres,
  output logic             w_pres,
`endif
  output logic [WIDTH-1:0] w_val,
  output logic [IDXW-1:0]  w_idx
);

  logic [LT_W-1:0] l_ext;
  logic [LT_W-1:0] r_ext;
  logic            r_less;
  logic            take_r;

  always_comb begin
    if (SIGNED != 0) begin
      l_ext = LT_W'($signed(l_val));
      r_ext = LT_W'($signed(r_val));
    end else begin
      l_ext = LT_W'(l_val);
      r_ext = LT_W'(r_val);
    end
    r_less = lt(r_ext, l_ext, SIGNED != 0);
  end

`ifdef ARGMIN_TREE_MASK_EN
  always_comb begin
    take_r = r_pres & (~l_pres | r_less);
    w_pres = l_pres | r_pres;
    if (!l_pres && !r_pres) begin
      w_val = '0;
      w_idx = '0;
    end else if (take_r) begin
      w_val = r_val;
      w_idx = r_idx;
    end else begin
      w_val = l_val;
      w_idx = l_idx;
    end
  end
`else
  always_comb begin
    take_r = r_less;
    w_val  = take_r ? r_val : l_val;
    w_idx  = take_r ? r_idx : l_idx;
  end
`endif

endmodule

// File: rtl/argmin_tree.sv
// argmin_tree: pipelined minimum / lowest-index finder over N channels.
// A binary tree of argmin_cmp2 nodes, one register per tree level, with
// valid/ready handshakes on both sides. The whole pipeline freezes while
// a result is offered and not taken; bubbles are not collapsed.
// Optional feature macro: ARGMIN_TREE_MASK_EN adds in_mask (per-channel
// participate bit) and out_none (beat had no participating channel).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data             : channel i at [i*WIDTH +: WIDTH]
//   in_mask, out_none   : only with ARGMIN_TREE_MASK_EN
//   out_valid/out_ready : output handshake
//   out_min, out_idx    : minimum value and lowest channel holding it
module argmin_tree
  import argmin_pkg::*;
#(
  parameter  int N      = ARGMIN_N,
  parameter  int WIDTH  = ARGMIN_WIDTH,
  parameter  int SIGNED = 0,
  localparam int IDXW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef ARGMIN_TREE_MASK_EN
  input  logic [N-1:0]       in_mask,
  output logic               out_none,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_min,
  output logic [IDXW-1:0]    out_idx
);

  localparam int LEVELS = argmin_levels(N);
  // Internal nodes are stored heap-style: node j has children 2j+1, 2j+2;
  // heap positions NODES..2N-2 are the input channels in order, so every
  // left subtree covers lower channel numbers than its right sibling.
  localparam int NODES  = N - 1;

  logic              stall;
  logic [LEVELS-1:0] vld_p;

  logic [WIDTH-1:0]  leaf_val [N];
  logic [IDXW-1:0]   leaf_idx [N];
  logic [WIDTH-1:0]  win_val  [NODES];
  logic [IDXW-1:0]   win_idx  [NODES];
  logic [WIDTH-1:0]  val_p    [NODES];
  logic [IDXW-1:0]   idx_p    [NODES];
`ifdef ARGMIN_TREE_MASK_EN
  logic              leaf_pres [N];
  logic              win_pres  [NODES];
  logic              pres_p    [NODES];
`endif

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign leaf_val[i] = in_data[i*WIDTH +: WIDTH];
    assign leaf_idx[i] = IDXW'(i);
`ifdef ARGMIN_TREE_MASK_EN
    assign leaf_pres[i] = in_mask[i];
`endif
  end

  for (genvar j = 0; j < NODES; j++) begin : g_node
    localparam int LC = 2*j + 1;
    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] rv;
    logic [IDXW-1:0]  li;
    logic [IDXW-1:0]  ri;
`ifdef ARGMIN_TREE_MASK_EN
    logic             lp;
    logic             rp;
`endif

    if (LC >= NODES) begin : g_from_leaf
      assign lv = leaf_val[LC-NODES];
      assign rv = leaf_val[LC-NODES+1];
      assign li = leaf_idx[LC-NODES];
      assign ri = leaf_idx[LC-NODES+1];
`ifdef ARGMIN_TREE_MASK_EN
      assign lp = leaf_pres[LC-NODES];
      assign rp = leaf_pres[LC-NODES+1];
`endif
    end else begin : g_from_node
      assign lv = val_p[LC];
      assign rv = val_p[LC+1];
      assign li = idx_p[LC];
      assign ri = idx_p[LC+1];
`ifdef ARGMIN_TREE_MASK_EN
      assign lp = pres_p[LC];
      assign rp = pres_p[LC+1];
`endif
    end

    argmin_cmp2 #(
      .WIDTH  (WIDTH),
      .IDXW   (IDXW),
      .SIGNED (SIGNED)
    ) u_cmp (
      .l_val  (lv),
      .l_idx  (li),
      .r_val  (rv),
      .r_idx  (ri),
`ifdef ARGMIN_TREE_MASK_EN
      .l_pres (lp),
      .r_pres (rp),
      .w_pres (win_pres[j]),
`endif
      .w_val  (win_val[j]),
      .w_idx  (win_idx[j])
    );
  end

  // ---- level registers: vld_p[k] qualifies tree depth LEVELS-1-k ----
  // Only the root data is cleared on reset, since it is visible on the
  // outputs; inner data is qualified by its valid and may hold garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p    <= '0;
      val_p[0] <= '0;
      idx_p[0] <= '0;
`ifdef ARGMIN_TREE_MASK_EN
      for (int j = 0; j < NODES; j++) pres_p[j] <= 1'b0;
`endif
    end else if (!stall) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < LEVELS; k++) vld_p[k] <= vld_p[k-1];
      for (int j = 0; j < NODES; j++) begin
        val_p[j] <= win_val[j];
        idx_p[j] <= win_idx[j];
`ifdef ARGMIN_TREE_MASK_EN
        pres_p[j] <= win_pres[j];
`endif
      end
    end
  end

  // ---- output: root register ----
  assign out_valid = vld_p[LEVELS-1];
  assign out_min   = val_p[0];
  assign out_idx   = idx_p[0];
`ifdef ARGMIN_TREE_MASK_EN
  assign out_none  = out_valid & ~pres_p[0];
`endif

endmodule

// File: tb/tb_argmin_tree.sv
// tb_argmin_tree: directed, table-driven bench for argmin_tree.
// Instances: A (N=4, 32b, unsigned), B (N=8, 32b, signed),
// C (N=8, 32b, unsigned, same stimulus as B), D (N=2, 8b, unsigned).
// Mask checks are compiled when ARGMIN_TREE_MASK_EN is defined.
module tb_argmin_tree;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- DUT A ----------------
  logic         a_valid, a_ready, a_in_ready, a_out_valid;
  logic [127:0] a_data;
  logic [31:0]  a_out_min;
  logic [1:0]   a_out_idx;
  // ---------------- DUT B / C ----------------
  logic         bc_valid, bc_ready;
  logic [255:0] bc_data;
  logic         b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [31:0]  b_out_min, c_out_min;
  logic [2:0]   b_out_idx, c_out_idx;
  // ---------------- DUT D ----------------
  logic         d_valid, d_ready, d_in_ready, d_out_valid;
  logic [15:0]  d_data;
  logic [7:0]   d_out_min;
  logic [0:0]   d_out_idx;
`ifdef ARGMIN_TREE_MASK_EN
  logic [3:0]   a_mask;
  logic [7:0]   bc_mask;
  logic [1:0]   d_mask;
  logic         a_none, b_none, c_none, d_none;
`endif

  argmin_tree #(.N(4), .WIDTH(32), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready), .in_data(a_data),
`ifdef ARGMIN_TREE_MASK_EN
    .in_mask(a_mask), .out_none(a_none),
`endif
    .out_valid(a_out_valid), .out_ready(a_ready), .out_min(a_out_min), .out_idx(a_out_idx));

  argmin_tree #(.N(8), .WIDTH(32), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(bc_valid), .in_ready(b_in_ready), .in_data(bc_data),
`ifdef ARGMIN_TREE_MASK_EN
    .in_mask(bc_mask), .out_none(b_none),
`endif
    .out_valid(b_out_valid), .out_ready(bc_ready), .out_min(b_out_min), .out_idx(b_out_idx));

  argmin_tree #(.N(8), .WIDTH(32), .SIGNED(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(bc_valid), .in_ready(c_in_ready), .in_data(bc_data),
`ifdef ARGMIN_TREE_MASK_EN
    .in_mask(bc_mask), .out_none(c_none),
`endif
    .out_valid(c_out_valid), .out_ready(bc_ready), .out_min(c_out_min), .out_idx(c_out_idx));

  argmin_tree #(.N(2), .WIDTH(8), .SIGNED(0)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_valid), .in_ready(d_in_ready), .in_data(d_data),
`ifdef ARGMIN_TREE_MASK_EN
    .in_mask(d_mask), .out_none(d_none),
`endif
    .out_valid(d_out_valid), .out_ready(d_ready), .out_min(d_out_min), .out_idx(d_out_idx));

  typedef struct {
    logic [127:0] din;
    logic [31:0]  emin;
    logic [1:0]   eidx;
  } vec4_t;

  typedef struct {
    logic [255:0] din;
    logic [31:0]  s_min;
    logic [2:0]   s_idx;
    logic [31:0]  u_min;
    logic [2:0]   u_idx;
  } vec8_t;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  emin;
    logic [0:0]  eidx;
  } vec2_t;

  vec4_t t4[7];
  vec8_t t8[6];
  vec2_t t2[4];

  function automatic logic [255:0] fill8(input logic [31:0] base,
                                         input int c1, input logic [31:0] v1,
                                         input int c2, input logic [31:0] v2);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = base;
    if (c1 >= 0) r[c1*32 +: 32] = v1;
    if (c2 >= 0) r[c2*32 +: 32] = v2;
    return r;
  endfunction

  // Reference: linear scan, strict less-than keeps the lowest index.
  function automatic logic [33:0] ref4(input logic [127:0] d);
    logic [31:0] m;
    logic [1:0]  ix;
    m  = d[31:0];
    ix = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (d[i*32 +: 32] < m) begin
        m  = d[i*32 +: 32];
        ix = 2'(i);
      end
    end
    return {ix, m};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    int          cyc, sent, got;
    logic        held;
    logic [31:0] hmin;
    logic [1:0]  hidx;
    logic [33:0] q[$];
    logic [33:0] e;
    logic [127:0] beats[16];
    logic [7:0]  pat;
    logic        expv;

    // ch0 is the least significant word of each din.
    t4[0] = '{{32'd3, 32'd9, 32'd3, 32'd5}, 32'd3, 2'd1};
    t4[1] = '{{32'h1234, 32'h1234, 32'h1234, 32'h1234}, 32'h1234, 2'd0};
    t4[2] = '{{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF}, 32'hFFFFFFFE, 2'd2};
    t4[3] = '{{32'd0, 32'd30, 32'd20, 32'd10}, 32'd0, 2'd3};
    t4[4] = '{{32'd2, 32'hFFFFFFFF, 32'd1, 32'h80000000}, 32'd1, 2'd1};
    t4[5] = '{{32'd0, 32'd0, 32'd8, 32'd0}, 32'd0, 2'd0};
    t4[6] = '{{32'd4, 32'd4, 32'd9, 32'd9}, 32'd4, 2'd2};

    t8[0] = '{fill8(32'd0, 6, 32'hFFFFFFFF, -1, 32'd0), 32'hFFFFFFFF, 3'd6, 32'd0, 3'd0};
    t8[1] = '{fill8(32'd7, 5, 32'h80000000, -1, 32'd0), 32'h80000000, 3'd5, 32'd7, 3'd0};
    t8[2] = '{fill8(32'hFFFFFFFF, -1, 32'd0, -1, 32'd0), 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF, 3'd0};
    t8[3] = '{fill8(32'd100, 3, 32'h7FFFFFFF, 4, 32'h80000000), 32'h80000000, 3'd4, 32'd100, 3'd0};
    t8[4] = '{fill8(32'd9, 2, 32'd3, 7, 32'd3), 32'd3, 3'd2, 32'd3, 3'd2};
    t8[5] = '{fill8(32'd0, 1, 32'hFFFFFFFE, 7, 32'hFFFFFFFE), 32'hFFFFFFFE, 3'd1, 32'd0, 3'd0};

    t2[0] = '{{8'h05, 8'h03}, 8'h03, 1'b0};
    t2[1] = '{{8'h02, 8'h09}, 8'h02, 1'b1};
    t2[2] = '{{8'hFF, 8'hFF}, 8'hFF, 1'b0};
    t2[3] = '{{8'h00, 8'h80}, 8'h00, 1'b1};

    a_valid = 0; a_ready = 1; a_data = '0;
    bc_valid = 0; bc_ready = 1; bc_data = '0;
    d_valid = 0; d_ready = 1; d_data = '0;
`ifdef ARGMIN_TREE_MASK_EN
    a_mask = '1; bc_mask = '1; d_mask = '1;
`endif

    // Reset state
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst a out_valid", a_out_valid, 0);
    chk("rst a out_min", a_out_min, 0);
    chk("rst a out_idx", a_out_idx, 0);
    chk("rst a in_ready", a_in_ready, 1);
    chk("rst b out_valid", b_out_valid, 0);
    chk("rst b in_ready", b_in_ready, 1);
    chk("rst c out_valid", c_out_valid, 0);
    chk("rst c in_ready", c_in_ready, 1);
    chk("rst d out_valid", d_out_valid, 0);
    chk("rst d in_ready", d_in_ready, 1);
`ifdef ARGMIN_TREE_MASK_EN
    chk("rst a none", a_none, 0);
    chk("rst b none", b_none, 0);
    chk("rst c none", c_none, 0);
    chk("rst d none", d_none, 0);
`endif

    // N=4 table, latency 2
    for (int v = 0; v < 7; v++) begin
      a_valid = 1; a_data = t4[v].din;
      @(negedge clk); a_valid = 0;
      @(negedge clk); #1;
      chk($sformatf("t4[%0d] valid", v), a_out_valid, 1);
      chk($sformatf("t4[%0d] min", v), a_out_min, t4[v].emin);
      chk($sformatf("t4[%0d] idx", v), a_out_idx, t4[v].eidx);
    end

    // N=8 table, latency 3, signed (B) and unsigned (C)
    for (int v = 0; v < 6; v++) begin
      bc_valid = 1; bc_data = t8[v].din;
      @(negedge clk); bc_valid = 0;
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("t8[%0d] s valid", v), b_out_valid, 1);
      chk($sformatf("t8[%0d] s min", v), b_out_min, t8[v].s_min);
      chk($sformatf("t8[%0d] s idx", v), b_out_idx, t8[v].s_idx);
      chk($sformatf("t8[%0d] u valid", v), c_out_valid, 1);
      chk($sformatf("t8[%0d] u min", v), c_out_min, t8[v].u_min);
      chk($sformatf("t8[%0d] u idx", v), c_out_idx, t8[v].u_idx);
    end

    // N=2 table, latency 1
    for (int v = 0; v < 4; v++) begin
      d_valid = 1; d_data = t2[v].din;
      @(negedge clk); d_valid = 0;
      #1;
      chk($sformatf("t2[%0d] valid", v), d_out_valid, 1);
      chk($sformatf("t2[%0d] min", v), d_out_min, t2[v].emin);
      chk($sformatf("t2[%0d] idx", v), d_out_idx, t2[v].eidx);
    end

    // Alternating in_valid: out_valid repeats the pattern two cycles later
    repeat (2) @(negedge clk);
    #1;
    pat = 8'b0011_0101;
    for (int c = 0; c < 12; c++) begin
      expv = (c >= 2 && c < 10) ? pat[c-2] : 1'b0;
      chk($sformatf("alt valid c%0d", c), a_out_valid, expv);
      if (expv) begin
        chk($sformatf("alt min c%0d", c), a_out_min, 32'(c - 2));
        chk($sformatf("alt idx c%0d", c), a_out_idx, 2'd2);
      end
      a_valid = (c < 8) ? pat[c] : 1'b0;
      a_data  = {32'd1000, 32'(c), 32'd1000, 32'd1000};
      @(negedge clk); #1;
    end
    a_valid = 0;

    // Back-to-back stream with downstream stall in cycles 5..9
    for (int i = 0; i < 16; i++)
      for (int ch = 0; ch < 4; ch++)
        beats[i][ch*32 +: 32] = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    cyc = 0; sent = 0; got = 0; held = 0; hmin = '0; hidx = '0;
    @(negedge clk);
    while (got < 16 && cyc < 300) begin
      a_ready = !(cyc >= 5 && cyc <= 9);
      if (sent < 16) begin a_valid = 1; a_data = beats[sent]; end
      else a_valid = 0;
      #1;
      chk($sformatf("stream in_ready c%0d", cyc), a_in_ready, !(a_out_valid && !a_ready));
      if (held) begin
        chk($sformatf("stream hold valid c%0d", cyc), a_out_valid, 1);
        chk($sformatf("stream hold min c%0d", cyc), a_out_min, hmin);
        chk($sformatf("stream hold idx c%0d", cyc), a_out_idx, hidx);
      end
      if (a_out_valid && a_ready) begin
        chk($sformatf("stream expected beat pending c%0d", cyc), q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk($sformatf("stream beat%0d min", got), a_out_min, e[31:0]);
          chk($sformatf("stream beat%0d idx", got), a_out_idx, e[33:32]);
        end
        got++;
      end
      if (a_valid && a_in_ready) begin
        q.push_back(ref4(a_data));
        sent++;
      end
      held = a_out_valid && !a_ready;
      hmin = a_out_min;
      hidx = a_out_idx;
      @(negedge clk);
      cyc++;
    end
    chk("stream beats sent", sent, 16);
    chk("stream beats received", got, 16);
    a_valid = 0; a_ready = 1;

    // Reset with two beats in flight in the 3-level tree
    @(negedge clk);
    bc_valid = 1; bc_data = fill8(32'd5, 1, 32'd2, -1, 32'd0);
    @(negedge clk);
    bc_data = fill8(32'd6, 3, 32'd1, -1, 32'd0);
    @(negedge clk);
    bc_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("flush b valid k%0d", k), b_out_valid, 0);
      chk($sformatf("flush c valid k%0d", k), c_out_valid, 0);
      @(negedge clk); #1;
    end

`ifdef ARGMIN_TREE_MASK_EN
    // Masked channels
    a_mask = 4'b1010; a_valid = 1; a_data = {32'd4, 32'd0, 32'd7, 32'd1};
    @(negedge clk); a_valid = 0;
    @(negedge clk); #1;
    chk("mask1010 min", a_out_min, 32'd4);
    chk("mask1010 idx", a_out_idx, 2'd3);
    chk("mask1010 none", a_none, 0);

    a_mask = 4'b0000; a_valid = 1; a_data = {32'd1, 32'd2, 32'd3, 32'd4};
    @(negedge clk); a_valid = 0;
    @(negedge clk); #1;
    chk("mask0 valid", a_out_valid, 1);
    chk("mask0 none", a_none, 1);
    chk("mask0 min", a_out_min, 32'd0);
    chk("mask0 idx", a_out_idx, 2'd0);

    a_mask = 4'b0001; a_valid = 1; a_data = {32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
    @(negedge clk); a_valid = 0;
    @(negedge clk); #1;
    chk("mask0001 min", a_out_min, 32'hFFFFFFFF);
    chk("mask0001 idx", a_out_idx, 2'd0);
    chk("mask0001 none", a_none, 0);
    a_mask = '1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
